// File: rtl/spi_iomem_bridge_pkg.sv
// Shared definitions for the SPI-to-iomem bridge: command codes, FSM encoding,
// read-underrun fill value and bus constants.
package spi_iomem_bridge_pkg;

    localparam logic [7:0]  CMD_WRITE  = 8'h01;
    localparam logic [7:0]  CMD_READ   = 8'h02;
    localparam logic [7:0]  CMD_STATUS = 8'h03;

    localparam logic [31:0] RD_FILL    = 32'hFFFF_FFFF;
    localparam logic [31:0] ADDR_STEP  = 32'd4;
    localparam logic [3:0]  WSTRB_ALL  = 4'hF;
    localparam logic [3:0]  WSTRB_READ = 4'h0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_RDUMMY,
        ST_RDATA,
        ST_STAT,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// N-stage synchroniser for the SPI pins plus one edge-detect flop, producing
// single-cycle SCK/CS event pulses and a MOSI copy aligned with them.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic spi_sck,
    input  logic spi_csn,
    input  logic spi_mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_fall,
    output logic cs_rise,
    output logic cs_active,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] csn_sync_q, csn_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sck_prev_q, sck_prev_d;
    logic                   csn_prev_q, csn_prev_d;
    logic                   sck_s, csn_s;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign csn_s  = csn_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    always_comb begin
        sck_sync_d  = (sck_sync_q << 1)  | SYNC_STAGES'(spi_sck);
        csn_sync_d  = (csn_sync_q << 1)  | SYNC_STAGES'(spi_csn);
        mosi_sync_d = (mosi_sync_q << 1) | SYNC_STAGES'(spi_mosi);
        sck_prev_d  = sck_s;
        csn_prev_d  = csn_s;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sck_sync_q  <= '0;
            csn_sync_q  <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            csn_prev_q  <= 1'b1;
        end else begin
            sck_sync_q  <= sck_sync_d;
            csn_sync_q  <= csn_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_prev_q  <= sck_prev_d;
            csn_prev_q  <= csn_prev_d;
        end
    end

    assign sck_rise  =  sck_s & ~sck_prev_q;
    assign sck_fall  = ~sck_s &  sck_prev_q;
    assign cs_fall   = ~csn_s &  csn_prev_q;
    assign cs_rise   =  csn_s & ~csn_prev_q;
    assign cs_active = ~csn_s;

endmodule

// File: rtl/spi_iomem_bridge.sv
// SPI mode-0 slave that turns write/read/status frames into single-word iomem
// transactions. Define SPI_IOMEM_AUTOINC_EN for address auto-increment bursts.
module spi_iomem_bridge
    import spi_iomem_bridge_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        spi_sck,
    input  logic        spi_csn,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        iomem_valid,
    input  logic        iomem_ready,
    output logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    input  logic [31:0] iomem_rdata,
    output logic        err
);

    logic sck_rise, sck_fall, cs_fall, cs_rise, cs_active, mosi_s;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .resetn    (resetn),
        .spi_sck   (spi_sck),
        .spi_csn   (spi_csn),
        .spi_mosi  (spi_mosi),
        .sck_rise  (sck_rise),
        .sck_fall  (sck_fall),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise),
        .cs_active (cs_active),
        .mosi_s    (mosi_s)
    );

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d, byte_cnt_q, byte_cnt_d;
    logic [6:0]  shift_in_q, shift_in_d;
    logic [23:0] acc_q, acc_d;
    logic [7:0]  shift_out_q, shift_out_d;
    logic [31:0] out_word_q, out_word_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        miso_q, miso_d, valid_q, valid_d, err_q, err_d;
    logic        rdata_ok_q, rdata_ok_d, discard_q, discard_d;
    logic        cmd_read_q, cmd_read_d, first_q, first_d, over_q, over_d;
    logic [7:0]  byte_in, load_byte;
    logic        byte_done, next_word;

    assign byte_in   = {shift_in_q, mosi_s};
    assign byte_done = sck_rise && (bit_cnt_q == 3'd7) && (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        if (cs_rise) begin
            state_d = ST_IDLE;
        end else if (cs_fall) begin
            state_d = ST_CMD;
        end else if (byte_done) begin
            case (state_q)
                ST_CMD: begin
                    if (valid_q)                                          state_d = ST_IGNORE;
                    else if (byte_in == CMD_WRITE || byte_in == CMD_READ) state_d = ST_ADDR;
                    else if (byte_in == CMD_STATUS)                       state_d = ST_STAT;
                    else                                                  state_d = ST_IGNORE;
                end
                ST_ADDR:   if (byte_cnt_q == 3'd3) state_d = cmd_read_q ? ST_RDUMMY : ST_WDATA;
                ST_RDUMMY: state_d = ST_RDATA;
                ST_STAT:   state_d = ST_IGNORE;
                default:   state_d = state_q;
            endcase
        end
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;  byte_cnt_d = byte_cnt_q;  shift_in_d = shift_in_q;
        acc_d = acc_q;  shift_out_d = shift_out_q;  out_word_d = out_word_q;
        addr_d = addr_q;  wdata_d = wdata_q;  rdata_d = rdata_q;  wstrb_d = wstrb_q;
        miso_d = miso_q;  valid_d = valid_q;  err_d = err_q;
        rdata_ok_d = rdata_ok_q;  discard_d = discard_q;  cmd_read_d = cmd_read_q;
        first_d = first_q;  over_d = over_q;
        load_byte = 8'h00;  next_word = 1'b0;

        if (valid_q && iomem_ready) begin
            valid_d   = 1'b0;
            discard_d = 1'b0;
            if (wstrb_q == WSTRB_READ && !discard_q) begin
                rdata_d    = iomem_rdata;
                rdata_ok_d = 1'b1;
            end
        end

        if (cs_rise) begin
            miso_d = 1'b0;
            if (valid_q && !iomem_ready) discard_d = 1'b1;
        end else if (cs_fall) begin
            bit_cnt_d = '0;  byte_cnt_d = '0;  shift_out_d = '0;  miso_d = 1'b0;  over_d = 1'b0;
        end else if (state_q != ST_IDLE) begin
            if (sck_rise) begin
                bit_cnt_d  = bit_cnt_q + 3'd1;
                shift_in_d = byte_in[6:0];
            end
            // The first bit of each byte is already on MISO, so only mid-byte falls shift.
            if (sck_fall && bit_cnt_q != 3'd0) begin
                miso_d      = shift_out_q[7];
                shift_out_d = {shift_out_q[6:0], 1'b0};
            end
            if (byte_done) begin
                byte_cnt_d = byte_cnt_q + 3'd1;
                case (state_q)
                    ST_CMD: begin
                        byte_cnt_d = '0;
                        cmd_read_d = (byte_in == CMD_READ);
                        if (valid_q)                     err_d     = 1'b1;
                        else if (byte_in == CMD_STATUS)  load_byte = {7'b0, err_q};
                    end
                    ST_ADDR: begin
                        acc_d = {acc_q[15:0], byte_in};
                        if (byte_cnt_q == 3'd3) begin
                            byte_cnt_d = '0;
                            first_d    = 1'b1;
                            addr_d     = {acc_q, byte_in};
                            if (cmd_read_q) begin
                                valid_d = 1'b1;  wstrb_d = WSTRB_READ;  rdata_ok_d = 1'b0;
                            end
                        end
                    end
                    ST_WDATA: begin
                        acc_d = {acc_q[15:0], byte_in};
                        if (byte_cnt_q == 3'd3) begin
                            byte_cnt_d = '0;
                            if (!over_q) begin
                                if (valid_q) begin
                                    err_d = 1'b1;
                                end else begin
                                    valid_d = 1'b1;  wstrb_d = WSTRB_ALL;  wdata_d = {acc_q, byte_in};
                                    addr_d  = first_q ? addr_q : addr_q + ADDR_STEP;
                                    first_d = 1'b0;
                                end
`ifndef SPI_IOMEM_AUTOINC_EN
                                over_d = 1'b1;
`endif
                            end
                        end
                    end
                    ST_RDUMMY: begin
                        byte_cnt_d = '0;
                        next_word  = 1'b1;
                    end
                    ST_RDATA: begin
                        if (!over_q) begin
                            if (byte_cnt_q == 3'd3) begin
                                byte_cnt_d = '0;
`ifdef SPI_IOMEM_AUTOINC_EN
                                next_word = 1'b1;
`else
                                over_d = 1'b1;
`endif
                            end else begin
                                load_byte  = out_word_q[31:24];
                                out_word_d = {out_word_q[23:0], 8'h00};
                            end
                        end
                    end
                    ST_STAT: err_d = 1'b0;
                    default: ;
                endcase

                // A word is ready only if its read completed; otherwise the pending read is stale.
                if (next_word) begin
                    if (rdata_ok_d) begin
                        load_byte  = rdata_d[31:24];
                        out_word_d = {rdata_d[23:0], 8'h00};
`ifdef SPI_IOMEM_AUTOINC_EN
                        if (!valid_q) begin
                            valid_d = 1'b1;  wstrb_d = WSTRB_READ;  rdata_ok_d = 1'b0;
                            addr_d  = addr_q + ADDR_STEP;
                        end
`endif
                    end else begin
                        load_byte  = RD_FILL[31:24];
                        out_word_d = {RD_FILL[23:0], 8'h00};
                        err_d      = 1'b1;
                        if (valid_q && !iomem_ready) discard_d = 1'b1;
                    end
                end
                if (over_d) load_byte = 8'hFF;
                miso_d      = load_byte[7];
                shift_out_d = {load_byte[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bit_cnt_q <= '0;  byte_cnt_q <= '0;  shift_in_q <= '0;  acc_q <= '0;
            shift_out_q <= '0;  out_word_q <= '0;  addr_q <= '0;  wdata_q <= '0;
            rdata_q <= '0;  wstrb_q <= '0;  miso_q <= 1'b0;  valid_q <= 1'b0;
            err_q <= 1'b0;  rdata_ok_q <= 1'b0;  discard_q <= 1'b0;
            cmd_read_q <= 1'b0;  first_q <= 1'b0;  over_q <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;  byte_cnt_q <= byte_cnt_d;  shift_in_q <= shift_in_d;
            acc_q <= acc_d;  shift_out_q <= shift_out_d;  out_word_q <= out_word_d;
            addr_q <= addr_d;  wdata_q <= wdata_d;  rdata_q <= rdata_d;  wstrb_q <= wstrb_d;
            miso_q <= miso_d;  valid_q <= valid_d;  err_q <= err_d;
            rdata_ok_q <= rdata_ok_d;  discard_q <= discard_d;
            cmd_read_q <= cmd_read_d;  first_q <= first_d;  over_q <= over_d;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = cs_active;
    assign iomem_valid = valid_q;
    assign iomem_wstrb = wstrb_q;
    assign iomem_addr  = addr_q;
    assign iomem_wdata = wdata_q;
    assign err         = err_q;

endmodule

// File: tb/tb_spi_iomem_bridge.sv
// Self-checking bench for spi_iomem_bridge: SPI master driver, iomem responder
// with a bus-transaction scoreboard, and an expected-MISO byte scoreboard.
module tb_spi_iomem_bridge;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_txn_t;

    typedef struct {
        logic [7:0] v;
        bit         care;
    } rx_exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        spi_sck = 1'b0, spi_csn = 1'b1, spi_mosi = 1'b0;
    logic        spi_miso, spi_miso_oe, iomem_valid, err;
    logic        iomem_ready = 1'b0;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr, iomem_wdata;
    logic [31:0] iomem_rdata = 32'h0;

    spi_iomem_bridge dut (
        .clk         (clk),
        .resetn      (resetn),
        .spi_sck     (spi_sck),
        .spi_csn     (spi_csn),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .err         (err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          ready_lat = 2;
    int          bus_count = 0;
    logic [31:0] rd_value = 32'h0;
    bus_txn_t    exp_bus[$];
    rx_exp_t     exp_rx[$];
    logic [7:0]  tx_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] tx, input logic [7:0] exp, input bit care);
        rx_exp_t e;
        e.v = exp;
        e.care = care;
        tx_q.push_back(tx);
        exp_rx.push_back(e);
    endtask

    task automatic send_word(input logic [31:0] w, input bit care);
        for (int i = 3; i >= 0; i--) send(w[8*i +: 8], 8'h00, care);
    endtask

    task automatic expect_bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus_txn_t t;
        t.addr = a;
        t.wdata = d;
        t.wstrb = s;
        exp_bus.push_back(t);
    endtask

    // Mode-0 master at clk/8; MISO is sampled just before each rising SCK edge.
    task automatic run_frame(input bit raise_cs);
        logic [7:0] tx, rx;
        rx_exp_t    e;
        spi_csn = 1'b0;
        repeat (8) @(negedge clk);
        while (tx_q.size() > 0) begin
            tx = tx_q.pop_front();
            for (int i = 7; i >= 0; i--) begin
                spi_mosi = tx[i];
                repeat (4) @(negedge clk);
                rx[i] = spi_miso;
                spi_sck = 1'b1;
                repeat (4) @(negedge clk);
                spi_sck = 1'b0;
            end
            e = exp_rx.pop_front();
            if (e.care) check("miso_byte", 32'(rx), 32'(e.v));
        end
        repeat (8) @(negedge clk);
        if (raise_cs) begin
            spi_csn = 1'b1;
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (iomem_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("bus_idle_timeout", 32'(iomem_valid), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    initial begin : bus_model
        int       wait_cnt;
        bus_txn_t e;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (iomem_ready) begin
                iomem_ready = 1'b0;
            end else if (iomem_valid) begin
                if (wait_cnt >= ready_lat) begin
                    wait_cnt    = 0;
                    iomem_ready = 1'b1;
                    iomem_rdata = rd_value;
                    bus_count++;
                    if (exp_bus.size() == 0) begin
                        check("bus_unexpected", 32'(exp_bus.size()), 32'd1);
                    end else begin
                        e = exp_bus.pop_front();
                        check("bus_addr", iomem_addr, e.addr);
                        check("bus_wstrb", 32'(iomem_wstrb), 32'(e.wstrb));
                        if (e.wstrb != 4'h0) check("bus_wdata", iomem_wdata, e.wdata);
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin : stimulus
        int base;

        repeat (3) @(negedge clk);
        check("rst_valid", 32'(iomem_valid), 32'd0);
        check("rst_wstrb", 32'(iomem_wstrb), 32'd0);
        check("rst_addr",  iomem_addr, 32'd0);
        check("rst_wdata", iomem_wdata, 32'd0);
        check("rst_miso",  32'(spi_miso), 32'd0);
        check("rst_oe",    32'(spi_miso_oe), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        resetn = 1'b1;
        repeat (4) @(negedge clk);

        // Single write
        ready_lat = 2;
        expect_bus(32'h2200_0004, 32'h1234_5678, 4'hF);
        send(8'h01, 8'h00, 1'b1);
        send_word(32'h2200_0004, 1'b1);
        send_word(32'h1234_5678, 1'b1);
        run_frame(1'b1);
        wait_idle();
        check("wr_err", 32'(err), 32'd0);
        check("wr_sb_empty", 32'(exp_bus.size()), 32'd0);

        // Read with quick ready, one extra byte past the word
        ready_lat = 5;
        rd_value  = 32'hCAFE_F00D;
        expect_bus(32'h2000_0100, 32'h0, 4'h0);
`ifdef SPI_IOMEM_AUTOINC_EN
        expect_bus(32'h2000_0104, 32'h0, 4'h0);
        expect_bus(32'h2000_0108, 32'h0, 4'h0);
`endif
        send(8'h02, 8'h00, 1'b1);
        send_word(32'h2000_0100, 1'b1);
        send(8'h00, 8'h00, 1'b1);
        send(8'h00, 8'hCA, 1'b1);
        send(8'h00, 8'hFE, 1'b1);
        send(8'h00, 8'hF0, 1'b1);
        send(8'h00, 8'h0D, 1'b1);
`ifdef SPI_IOMEM_AUTOINC_EN
        send(8'h00, 8'hCA, 1'b1);
`else
        send(8'h00, 8'hFF, 1'b1);
`endif
        run_frame(1'b1);
        wait_idle();
        check("rd_err", 32'(err), 32'd0);
        check("rd_sb_empty", 32'(exp_bus.size()), 32'd0);

        // Read underrun, then two status frames
        ready_lat = 200;
        rd_value  = 32'h1111_1111;
        expect_bus(32'h2000_0200, 32'h0, 4'h0);
        send(8'h02, 8'h00, 1'b1);
        send_word(32'h2000_0200, 1'b1);
        send(8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) send(8'h00, 8'hFF, 1'b1);
        run_frame(1'b1);
        wait_idle();
        check("underrun_err", 32'(err), 32'd1);
        ready_lat = 2;
        send(8'h03, 8'h00, 1'b1);
        send(8'h00, 8'h01, 1'b1);
        run_frame(1'b1);
        check("stat1_err_cleared", 32'(err), 32'd0);
        send(8'h03, 8'h00, 1'b1);
        send(8'h00, 8'h00, 1'b1);
        run_frame(1'b1);

        // Abort after three address bytes, then a normal write
        base = bus_count;
        send(8'h01, 8'h00, 1'b1);
        send(8'h22, 8'h00, 1'b1);
        send(8'h00, 8'h00, 1'b1);
        send(8'h00, 8'h00, 1'b1);
        run_frame(1'b1);
        check("abort_no_bus", 32'(bus_count - base), 32'd0);
        check("abort_valid", 32'(iomem_valid), 32'd0);
        expect_bus(32'h2200_0008, 32'hAABB_CCDD, 4'hF);
        send(8'h01, 8'h00, 1'b1);
        send_word(32'h2200_0008, 1'b1);
        send_word(32'hAABB_CCDD, 1'b1);
        run_frame(1'b1);
        wait_idle();
        check("after_abort_sb", 32'(exp_bus.size()), 32'd0);
        check("after_abort_err", 32'(err), 32'd0);

        // Unknown command
        base = bus_count;
        send(8'h7E, 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) send(8'(8'h01 + i), 8'h00, 1'b1);
        run_frame(1'b1);
        wait_idle();
        check("ignore_no_bus", 32'(bus_count - base), 32'd0);
        check("ignore_err", 32'(err), 32'd0);

        // Multi-word write
        base = bus_count;
        expect_bus(32'h2100_0000, 32'h1111_1111, 4'hF);
`ifdef SPI_IOMEM_AUTOINC_EN
        expect_bus(32'h2100_0004, 32'h2222_2222, 4'hF);
        expect_bus(32'h2100_0008, 32'h3333_3333, 4'hF);
`endif
        send(8'h01, 8'h00, 1'b1);
        send_word(32'h2100_0000, 1'b1);
        send_word(32'h1111_1111, 1'b1);
        send_word(32'h2222_2222, 1'b0);
        send_word(32'h3333_3333, 1'b0);
        run_frame(1'b1);
        wait_idle();
`ifdef SPI_IOMEM_AUTOINC_EN
        check("burst_count", 32'(bus_count - base), 32'd3);
`else
        check("burst_count", 32'(bus_count - base), 32'd1);
`endif
        check("burst_sb_empty", 32'(exp_bus.size()), 32'd0);

        // Reset while a read is outstanding
        ready_lat = 1000;
        send(8'h02, 8'h00, 1'b1);
        send_word(32'h2000_0300, 1'b1);
        run_frame(1'b0);
        check("pre_rst_valid", 32'(iomem_valid), 32'd1);
        check("pre_rst_addr", iomem_addr, 32'h2000_0300);
        resetn = 1'b0;
        #1;
        check("mid_rst_valid", 32'(iomem_valid), 32'd0);
        check("mid_rst_addr", iomem_addr, 32'd0);
        check("mid_rst_wstrb", 32'(iomem_wstrb), 32'd0);
        check("mid_rst_oe", 32'(spi_miso_oe), 32'd0);
        @(negedge clk);
        spi_csn = 1'b1;
        repeat (4) @(negedge clk);
        resetn = 1'b1;
        repeat (8) @(negedge clk);
        check("final_sb_empty", 32'(exp_bus.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
